// File: rtl/cdc_fifo_rd_ctrl.sv
// Async FIFO read-side controller: syncs the write pointer and pops words
// into a registered rd_data/rd_valid output. Optional: CDC_FIFO_RD_LEVEL_EN.
//
// Ports:
//   rd_clk, rd_rst_n    read clock, async active-low reset
//   rd_wptr_gray        Gray write pointer from the write domain
//   mem_data / rd_addr  memory read port (data combinational from addr)
//   rd_ready            consumer accepts rd_data
//   rd_ptr_gray         registered Gray read pointer to the write domain
//   rd_data, rd_valid   registered output word and its valid flag
//   rd_empty            no unread word in memory (read-domain view)
//   rd_level            memory occupancy (only with CDC_FIFO_RD_LEVEL_EN)
module cdc_fifo_rd_ctrl #(
  parameter int DW          = 32,
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic [ADDRSIZE:0]   rd_wptr_gray,
  input  logic [DW-1:0]       mem_data,
  input  logic                rd_ready,
  output logic [ADDRSIZE:0]   rd_ptr_gray,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic                rd_empty
`ifdef CDC_FIFO_RD_LEVEL_EN
  ,
  output logic [ADDRSIZE:0]   rd_level
`endif
);

  localparam int PW = ADDRSIZE + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] wq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_nxt;
  logic          pop;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd_wptr_gray};
    end
  end

  assign wq       = sync_q[SYNC_STAGES-1];
  assign rd_empty = (rd_ptr_gray == wq);
  assign pop      = !rd_empty && (!rd_valid || rd_ready);
  assign rbin_nxt = rbin + PW'(pop);
  assign rd_addr  = rbin[ADDRSIZE-1:0];

  // Gray pointer is registered from rbin_nxt so it moves on the same
  // edge as rbin and never glitches toward the write domain.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
    end else begin
      rbin        <= rbin_nxt;
      rd_ptr_gray <= rbin_nxt ^ (rbin_nxt >> 1);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        pop: begin
          rd_data  <= mem_data;
          rd_valid <= 1'b1;
        end
        !pop && rd_ready: begin
          rd_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CDC_FIFO_RD_LEVEL_EN
  logic [PW-1:0] wbin;

  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(wq >> i);
    end
  end

  assign rd_level = wbin - rbin;
`endif

endmodule

// File: tb/tb_cdc_fifo_rd_ctrl.sv
// Self-checking bench for cdc_fifo_rd_ctrl: write-side model with a
// word queue scoreboard, directed corner cases and a random phase.
module tb_cdc_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wg;
  logic [31:0] mem_data;
  logic        rd_ready;
  logic [4:0]  rd_ptr_gray;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_empty;
`ifdef CDC_FIFO_RD_LEVEL_EN
  logic [4:0]  rd_level;
`endif

  logic [31:0] mem [16];
  logic [31:0] q [$];
  int          wbin;
  int          written;
  int          consumed;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  assign mem_data = mem[rd_addr];

  cdc_fifo_rd_ctrl dut (
    .rd_clk       (clk),
    .rd_rst_n     (rst_n),
    .rd_wptr_gray (wg),
    .mem_data     (mem_data),
    .rd_ready     (rd_ready),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_empty     (rd_empty)
`ifdef CDC_FIFO_RD_LEVEL_EN
    ,
    .rd_level     (rd_level)
`endif
  );

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    mem[wbin % 16] = d;
    q.push_back(d);
    wbin++;
    written++;
    wg = gray(wbin);
  endtask

  // One rd_clk cycle; a word handed over on this edge is scored.
  task automatic cycle();
    if (rd_valid && rd_ready) begin
      if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
      else chk("data", rd_data, q.pop_front());
      consumed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wg       = '0;
    wbin     = 0;
    written  = 0;
    consumed = 0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int first_v;
  int last_v;
  int nv;

  initial begin
    checks   = 0;
    errors   = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 + i;
    rst_n = 1'b0;
    wg    = '0;
    #1;
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ptr", {27'd0, rd_ptr_gray}, 0);
    chk("rst_empty", {31'd0, rd_empty}, 1);
    chk("rst_addr", {28'd0, rd_addr}, 0);
    do_reset();

    // First word latency
    rd_ready = 1'b1;
    push_word(32'hA5A5A5A5);
    cycle();
    chk("lat_e1", {31'd0, rd_valid}, 0);
    cycle();
    chk("lat_e2", {31'd0, rd_valid}, 0);
    chk("lat_e2_empty", {31'd0, rd_empty}, 0);
    cycle();
    chk("lat_e3", {31'd0, rd_valid}, 1);
    chk("lat_data", rd_data, 32'hA5A5A5A5);
    chk("lat_ptr", {27'd0, rd_ptr_gray}, 1);
    chk("lat_empty", {31'd0, rd_empty}, 1);
    cycle();
    chk("lat_clear", {31'd0, rd_valid}, 0);

    // Full memory drains at one word per cycle
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word({16'hC0DE, 16'(i)});
    first_v = -1;
    last_v  = -1;
    nv      = 0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (rd_valid) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    chk("full_count", nv, 16);
    chk("full_span", last_v - first_v + 1, 16);
    chk("full_ptr", {27'd0, rd_ptr_gray}, 32'h18);
    chk("full_empty", {31'd0, rd_empty}, 1);

    // Back-pressure holds the output word
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word($urandom);
    repeat (5) cycle();
    chk("bp_ptr", {27'd0, rd_ptr_gray}, 1);
    chk("bp_valid", {31'd0, rd_valid}, 1);
    chk("bp_data", rd_data, q[0]);
    rd_ready = 1'b1;
    cycle();
    chk("bp_b2b1", {31'd0, rd_valid}, 1);
    cycle();
    chk("bp_b2b2", {31'd0, rd_valid}, 1);
    cycle();
    chk("bp_done", {31'd0, rd_valid}, 0);
    chk("bp_q", q.size(), 0);

    // Pointer wrap from 31 to 1
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      push_word($urandom);
      repeat (4) cycle();
    end
    chk("wrap_pre", {27'd0, rd_ptr_gray}, {27'd0, gray(31)});
    push_word($urandom);
    push_word($urandom);
    repeat (6) cycle();
    chk("wrap_ptr", {27'd0, rd_ptr_gray}, {27'd0, gray(33)});
    chk("wrap_empty", {31'd0, rd_empty}, 1);
    chk("wrap_q", q.size(), 0);

`ifdef CDC_FIFO_RD_LEVEL_EN
    do_reset();
    rd_ready = 1'b0;
    push_word($urandom);
    repeat (4) cycle();
    chk("lvl_0", {27'd0, rd_level}, 0);
    push_word($urandom);
    push_word($urandom);
    repeat (4) cycle();
    chk("lvl_2", {27'd0, rd_level}, 2);
    rd_ready = 1'b1;
    cycle();
    chk("lvl_1", {27'd0, rd_level}, 1);
    cycle();
    chk("lvl_0b", {27'd0, rd_level}, 0);
    repeat (3) cycle();
`endif

    // Random traffic against the queue model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) != 0 && (written - consumed) < 16)
        push_word($urandom);
      rd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rd_ready = 1'b1;
    repeat (24) cycle();
    chk("rnd_q", q.size(), 0);
    chk("rnd_cnt", consumed, written);
    chk("rnd_ptr", {27'd0, rd_ptr_gray}, {27'd0, gray(wbin)});
    chk("rnd_empty", {31'd0, rd_empty}, 1);

    // Reset with a held word and 4 pending words
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    repeat (5) cycle();
    chk("mr_pre", {31'd0, rd_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, rd_valid}, 0);
    chk("mr_data", rd_data, 0);
    chk("mr_ptr", {27'd0, rd_ptr_gray}, 0);
    chk("mr_addr", {28'd0, rd_addr}, 0);
    wg = '0;
    #1;
    chk("mr_empty", {31'd0, rd_empty}, 1);
    do_reset();
    repeat (3) cycle();
    chk("mr_after", {31'd0, rd_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
